// File: rtl/cic_decimator_mc.sv
// Multi-channel CIC decimator with runtime power-of-two rate, TDM channel tags and
// a registered valid/ready output. Integrators per channel, two-stage comb/scale pipeline.
module cic_decimator_mc #(
  parameter  int N_CH      = 2,
  parameter  int ORDER     = 3,
  parameter  int LOG2_RMAX = 6,
  parameter  int DATA_W    = 24,
  localparam int ACC_W     = DATA_W + ORDER * LOG2_RMAX,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int K_W       = $clog2(LOG2_RMAX + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CH_W-1:0]   i_ch,
  input  logic [K_W-1:0]    i_rate_k,
  input  logic              i_rate_wr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CH_W-1:0]   o_ch,
  output logic              o_ovr,
  output logic              o_err
);

  localparam logic [CH_W:0]          NCH_L     = (CH_W + 1)'(N_CH);
  localparam logic [K_W-1:0]         K_ONE_L   = {{(K_W - 1){1'b0}}, 1'b1};
  localparam logic [K_W-1:0]         K_MAX_L   = K_W'(LOG2_RMAX);
  localparam logic [LOG2_RMAX-1:0]   CNT_ONE_L = {{(LOG2_RMAX - 1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0]  SAT_MAX_L = (ACC_W + 1)'({1'b0, {(DATA_W - 1){1'b1}}});
  localparam logic signed [ACC_W:0]  SAT_MIN_L = ~SAT_MAX_L;

  // Gain normalisation: divide by R^ORDER = 2^(ORDER*k), round half up, clamp to DATA_W.
  function automatic logic [DATA_W-1:0] scale_sat(input logic [ACC_W-1:0] x,
                                                  input logic [K_W-1:0]   k);
    logic signed [ACC_W:0] xe;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shr_v;
    logic [DATA_W-1:0]     res;
    int unsigned           sh;
    sh    = ORDER * 32'(k);
    xe    = signed'({x[ACC_W-1], x});
    rnd   = signed'({{ACC_W{1'b0}}, 1'b1} << (sh - 1));
    shr_v = (xe + rnd) >>> sh;
    if (shr_v > SAT_MAX_L) begin
      res = SAT_MAX_L[DATA_W-1:0];
    end else if (shr_v < SAT_MIN_L) begin
      res = SAT_MIN_L[DATA_W-1:0];
    end else begin
      res = shr_v[DATA_W-1:0];
    end
    return res;
  endfunction

  logic [ACC_W-1:0]     integ_r [N_CH][ORDER];
  logic [ACC_W-1:0]     dly_r   [N_CH][ORDER];
  logic [LOG2_RMAX-1:0] cnt_r   [N_CH];
  logic [K_W-1:0]       k_r;

  logic                 ch_ok_s;
  logic [CH_W-1:0]      ch_idx_s;
  logic                 acc_s;
  logic                 ev_s;
  logic                 k_legal_s;
  logic [LOG2_RMAX-1:0] rmask_s;
  logic [ACC_W-1:0]     din_ext_s;
  logic [ACC_W-1:0]     integ_nxt_s [ORDER];

  logic                 s1_ev_r;
  logic [CH_W-1:0]      s1_ch_r;
  logic [ACC_W-1:0]     s1_val_r;
  logic [ACC_W-1:0]     comb_x_s [ORDER+1];
  logic                 s2_ev_r;
  logic [CH_W-1:0]      s2_ch_r;
  logic [ACC_W-1:0]     s2_val_r;
  logic [DATA_W-1:0]    scaled_s;

  // Input qualification, decimation event detect and the cascaded integrator sums.
  always_comb begin
    ch_ok_s   = ({1'b0, i_ch} < NCH_L);
    ch_idx_s  = ch_ok_s ? i_ch : {CH_W{1'b0}};
    acc_s     = i_valid & ~i_rate_wr & ch_ok_s;
    k_legal_s = (i_rate_k >= K_ONE_L) && (i_rate_k <= K_MAX_L);
    rmask_s   = ~({LOG2_RMAX{1'b1}} << k_r);
    ev_s      = (cnt_r[ch_idx_s] == rmask_s);
    din_ext_s = {{(ACC_W - DATA_W){i_data[DATA_W-1]}}, i_data};
    integ_nxt_s[0] = integ_r[ch_idx_s][0] + din_ext_s;
    for (int j = 1; j < ORDER; j++) begin
      integ_nxt_s[j] = integ_r[ch_idx_s][j] + integ_nxt_s[j-1];
    end
  end

  // Per-channel integrator and decimation counter state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_r[c] <= {LOG2_RMAX{1'b0}};
        for (int j = 0; j < ORDER; j++) integ_r[c][j] <= {ACC_W{1'b0}};
      end
    end else if (i_rate_wr) begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_r[c] <= {LOG2_RMAX{1'b0}};
        for (int j = 0; j < ORDER; j++) integ_r[c][j] <= {ACC_W{1'b0}};
      end
    end else if (acc_s) begin
      for (int j = 0; j < ORDER; j++) integ_r[ch_idx_s][j] <= integ_nxt_s[j];
      cnt_r[ch_idx_s] <= ev_s ? {LOG2_RMAX{1'b0}} : cnt_r[ch_idx_s] + CNT_ONE_L;
    end
  end

  // Stage 1: capture the last integrator output with its channel and event tag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_ev_r  <= 1'b0;
      s1_ch_r  <= {CH_W{1'b0}};
      s1_val_r <= {ACC_W{1'b0}};
    end else if (i_rate_wr) begin
      s1_ev_r  <= 1'b0;
      s1_ch_r  <= {CH_W{1'b0}};
      s1_val_r <= {ACC_W{1'b0}};
    end else begin
      s1_ev_r  <= acc_s & ev_s;
      s1_ch_r  <= ch_idx_s;
      s1_val_r <= integ_nxt_s[ORDER-1];
    end
  end

  // Comb cascade at the decimated rate, using the channel's delay line.
  always_comb begin
    comb_x_s[0] = s1_val_r;
    for (int j = 0; j < ORDER; j++) begin
      comb_x_s[j+1] = comb_x_s[j] - dly_r[s1_ch_r][j];
    end
  end

  // Stage 2: register comb result and advance the channel's comb delays on events only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_ev_r  <= 1'b0;
      s2_ch_r  <= {CH_W{1'b0}};
      s2_val_r <= {ACC_W{1'b0}};
      for (int c = 0; c < N_CH; c++) begin
        for (int j = 0; j < ORDER; j++) dly_r[c][j] <= {ACC_W{1'b0}};
      end
    end else if (i_rate_wr) begin
      s2_ev_r  <= 1'b0;
      s2_ch_r  <= {CH_W{1'b0}};
      s2_val_r <= {ACC_W{1'b0}};
      for (int c = 0; c < N_CH; c++) begin
        for (int j = 0; j < ORDER; j++) dly_r[c][j] <= {ACC_W{1'b0}};
      end
    end else begin
      s2_ev_r  <= s1_ev_r;
      s2_ch_r  <= s1_ch_r;
      s2_val_r <= comb_x_s[ORDER];
      if (s1_ev_r) begin
        for (int j = 0; j < ORDER; j++) dly_r[s1_ch_r][j] <= comb_x_s[j];
      end
    end
  end

  // Scaling is combinational ahead of the output register.
  always_comb begin
    scaled_s = scale_sat(s2_val_r, k_r);
  end

  // Output register with valid/ready hold; a result arriving while held is dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= {DATA_W{1'b0}};
      o_ch    <= {CH_W{1'b0}};
      o_ovr   <= 1'b0;
    end else if (i_rate_wr) begin
      o_valid <= 1'b0;
      o_data  <= {DATA_W{1'b0}};
      o_ch    <= {CH_W{1'b0}};
      o_ovr   <= 1'b0;
    end else if (s2_ev_r) begin
      if (o_valid && !i_ready) begin
        o_ovr <= 1'b1;
      end else begin
        o_valid <= 1'b1;
        o_data  <= scaled_s;
        o_ch    <= s2_ch_r;
      end
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

  // Active rate and sticky error flag; an illegal rate keeps the old k but still flushes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      k_r   <= K_ONE_L;
      o_err <= 1'b0;
    end else if (i_rate_wr) begin
      if (k_legal_s) k_r <= i_rate_k;
      o_err <= ~k_legal_s;
    end else if (i_valid && !ch_ok_s) begin
      o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cic_decimator_mc.sv
// Self-checking bench for cic_decimator_mc: table-driven DC vectors through a scoreboard,
// plus hand sequences for latency, backpressure, rate writes, illegal channel and async reset.
module tb_cic_decimator_mc;

  localparam int ORDER = 3;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [23:0] i_data;
  logic [1:0]  i_ch;
  logic [2:0]  i_rate_k;
  logic        i_rate_wr;
  logic        i_ready;
  logic        o_valid;
  logic [23:0] o_data;
  logic [1:0]  o_ch;
  logic        o_ovr;
  logic        o_err;

  cic_decimator_mc #(.N_CH(3), .ORDER(ORDER), .LOG2_RMAX(6), .DATA_W(24)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data), .i_ch(i_ch),
    .i_rate_k(i_rate_k), .i_rate_wr(i_rate_wr), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_ch(o_ch), .o_ovr(o_ovr), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [23:0] data;
    bit          chk;
  } exp_t;

  typedef struct {
    logic [2:0]  k;
    int          nch;
    logic [23:0] d0;
    logic [23:0] d1;
    logic [23:0] e0;
    logic [23:0] e1;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[6];
  int   cnt_m[3];
  int   outn_m[3];
  int   k_m;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Scoreboard: every accepted output is popped and compared.
  always @(negedge clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got ch=%0d data=%h, required no output (t=%0t)", o_ch, o_data, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_ch", {30'b0, o_ch}, e.ch);
        if (e.chk) chk("out_data", {8'b0, o_data}, {8'b0, e.data});
      end
    end
  end

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      cnt_m[c]  = 0;
      outn_m[c] = 0;
    end
    sbq.delete();
  endtask

  task automatic idle();
    @(posedge clk); #1;
    i_valid   = 1'b0;
    i_rate_wr = 1'b0;
  endtask

  task automatic send(input int ch, input logic [23:0] d, input logic [23:0] ex,
                      input bit keep, input bit chk_en);
    exp_t e;
    @(posedge clk); #1;
    i_valid   = 1'b1;
    i_rate_wr = 1'b0;
    i_ch      = 2'(ch);
    i_data    = d;
    if (ch < 3) begin
      if (cnt_m[ch] == (1 << k_m) - 1) begin
        cnt_m[ch] = 0;
        if (keep) begin
          e.ch   = ch;
          e.data = ex;
          e.chk  = chk_en && (outn_m[ch] >= ORDER);
          sbq.push_back(e);
        end
        outn_m[ch]++;
      end else begin
        cnt_m[ch]++;
      end
    end
  endtask

  task automatic rate_wr(input logic [2:0] k, input bit legal);
    @(posedge clk); #1;
    i_rate_wr = 1'b1;
    i_rate_k  = k;
    i_valid   = 1'b1;
    i_ch      = 2'd0;
    i_data    = 24'h3FFFFF;
    @(posedge clk); #1;
    i_rate_wr = 1'b0;
    i_valid   = 1'b0;
    model_clear();
    if (legal) k_m = int'(k);
    chk("wr_valid", {31'b0, o_valid}, 32'd0);
    chk("wr_ovr", {31'b0, o_ovr}, 32'd0);
    chk("wr_err", {31'b0, o_err}, legal ? 32'd0 : 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && sbq.size() > 0; t++) idle();
    chk("drain_empty", sbq.size(), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{k: 3'd3, nch: 1, d0: 24'd1000,   d1: 24'd0,      e0: 24'd1000,   e1: 24'd0};
    vecs[1] = '{k: 3'd2, nch: 2, d0: 24'd5000,   d1: 24'hFFEC78, e0: 24'd5000,   e1: 24'hFFEC78};
    vecs[2] = '{k: 3'd6, nch: 1, d0: 24'h7FFFFF, d1: 24'd0,      e0: 24'h7FFFFF, e1: 24'd0};
    vecs[3] = '{k: 3'd6, nch: 1, d0: 24'h800000, d1: 24'd0,      e0: 24'h800000, e1: 24'd0};
    vecs[4] = '{k: 3'd1, nch: 2, d0: 24'hFFFFFF, d1: 24'd123456, e0: 24'hFFFFFF, e1: 24'd123456};
    vecs[5] = '{k: 3'd4, nch: 2, d0: 24'h800000, d1: 24'h7FFFFF, e0: 24'h800000, e1: 24'h7FFFFF};

    i_rst = 1'b1; i_valid = 1'b0; i_data = 24'd0; i_ch = 2'd0;
    i_rate_k = 3'd1; i_rate_wr = 1'b0; i_ready = 1'b1;
    k_m = 1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_data", {8'b0, o_data}, 32'd0);
    chk("rst_ch", {30'b0, o_ch}, 32'd0);
    chk("rst_ovr", {31'b0, o_ovr}, 32'd0);
    chk("rst_err", {31'b0, o_err}, 32'd0);
    i_rst = 1'b0;

    // Default k=1 after reset, and the two-edge output latency.
    send(0, 24'd200, 24'd200, 1'b1, 1'b1);
    send(0, 24'd200, 24'd200, 1'b1, 1'b1);
    idle(); chk("lat_e0", {31'b0, o_valid}, 32'd0);
    idle(); chk("lat_e1", {31'b0, o_valid}, 32'd0);
    idle(); chk("lat_e2", {31'b0, o_valid}, 32'd1);
    for (int i = 0; i < 10; i++) send(0, 24'd200, 24'd200, 1'b1, 1'b1);
    drain();

    // DC vectors at several rates, levels and channel mixes.
    foreach (vecs[v]) begin
      rate_wr(vecs[v].k, 1'b1);
      for (int i = 0; i < 6 * (1 << vecs[v].k); i++) begin
        for (int c = 0; c < vecs[v].nch; c++) begin
          send(c, (c == 0) ? vecs[v].d0 : vecs[v].d1, (c == 0) ? vecs[v].e0 : vecs[v].e1, 1'b1, 1'b1);
        end
      end
      drain();
      chk("vec_ovr", {31'b0, o_ovr}, 32'd0);
      chk("vec_err", {31'b0, o_err}, 32'd0);
    end

    // Backpressure: first result held, second dropped with overrun flagged.
    rate_wr(3'd2, 1'b1);
    for (int i = 0; i < 20; i++) send(0, 24'd700, 24'd700, 1'b1, 1'b1);
    drain();
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 24'd700, 24'd700, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(0, 24'hFFF448, 24'hFFF448, 1'b0, 1'b0);
    repeat (3) idle();
    chk("bp_valid", {31'b0, o_valid}, 32'd1);
    chk("bp_data", {8'b0, o_data}, 32'd700);
    chk("bp_ovr", {31'b0, o_ovr}, 32'd1);
    i_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(0, 24'hFFF448, 24'hFFF448, 1'b1, i >= 8);
    drain();
    chk("bp_ovr_sticky", {31'b0, o_ovr}, 32'd1);

    // Illegal channel: flagged and otherwise invisible.
    send(3, 24'h400000, 24'd0, 1'b0, 1'b0);
    idle();
    chk("badch_err", {31'b0, o_err}, 32'd1);
    for (int i = 0; i < 8; i++) send(0, 24'hFFF448, 24'hFFF448, 1'b1, 1'b1);

    // Mid-stream rate write to k=4, then an illegal k=7 that must keep R=16.
    rate_wr(3'd4, 1'b1);
    for (int i = 0; i < 80; i++) begin
      send(0, 24'd2500, 24'd2500, 1'b1, 1'b1);
      send(1, 24'hFFF63C, 24'hFFF63C, 1'b1, 1'b1);
    end
    drain();
    rate_wr(3'd7, 1'b0);
    for (int i = 0; i < 80; i++) send(0, 24'd2500, 24'd2500, 1'b1, 1'b1);
    drain();
    chk("k7_err_sticky", {31'b0, o_err}, 32'd1);

    // Async reset pulse between edges while a result is held and flags are set.
    rate_wr(3'd2, 1'b1);
    i_ready = 1'b0;
    for (int i = 0; i < 12; i++) send(0, 24'd1500, 24'd1500, 1'b1, 1'b1);
    send(3, 24'd0, 24'd0, 1'b0, 1'b0);
    repeat (3) idle();
    chk("pre_rst_valid", {31'b0, o_valid}, 32'd1);
    chk("pre_rst_ovr", {31'b0, o_ovr}, 32'd1);
    chk("pre_rst_err", {31'b0, o_err}, 32'd1);
    #1 i_rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, o_valid}, 32'd0);
    chk("arst_data", {8'b0, o_data}, 32'd0);
    chk("arst_ch", {30'b0, o_ch}, 32'd0);
    chk("arst_ovr", {31'b0, o_ovr}, 32'd0);
    chk("arst_err", {31'b0, o_err}, 32'd0);
    #1 i_rst = 1'b0;
    model_clear();
    k_m = 1;
    i_ready = 1'b1;
    send(0, 24'd1500, 24'd1500, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("arst_no_out", {31'b0, o_valid}, 32'd0);
    end
    for (int i = 0; i < 11; i++) send(0, 24'd1500, 24'd1500, 1'b1, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
